// File: rtl/mem_stage_ext.sv
// MEM pipeline stage: latches EX results, completes variable-latency data SRAM
// loads with byte/half/word extension, and feeds WB and the ID forwarding path.
module mem_stage_ext #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RF_AW   = 5,
    parameter int STALL_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [STALL_W-1:0]  stall,
    input  logic [PC_W-1:0]     ex_pc,
    input  logic                ex_mem_en,
    input  logic [DATA_W/8-1:0] ex_mem_wen,
    input  logic [2:0]          ex_load_op,
    input  logic                ex_sel_rf_res,
    input  logic                ex_rf_we,
    input  logic [RF_AW-1:0]    ex_rf_waddr,
    input  logic [DATA_W-1:0]   ex_result,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    input  logic                data_sram_rvalid,
    output logic                stallreq_mem,
    output logic [PC_W-1:0]     wb_pc,
    output logic                wb_rf_we,
    output logic [RF_AW-1:0]    wb_rf_waddr,
    output logic [DATA_W-1:0]   wb_rf_wdata,
    output logic                fwd_rf_we,
    output logic [RF_AW-1:0]    fwd_rf_waddr,
    output logic [DATA_W-1:0]   fwd_rf_wdata
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              mem_en;
        logic [BE_W-1:0]   wen;
        logic [2:0]        load_op;
        logic              sel_rf_res;
        logic              rf_we;
        logic [RF_AW-1:0]  rf_waddr;
        logic [DATA_W-1:0] result;
    } mem_reg_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

    mem_reg_t          mem_q;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q;
    logic              buf_pend_q, buf_pend_d, buf_cap;
    logic              is_load, ld_wait, reg_clear, reg_load, reg_hold;
    logic              use_buf, we_gate;
    logic [DATA_W-1:0] ld_raw, ld_ext, wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              unused_stall;

    // only the MEM and WB stall bits matter to this stage
    assign unused_stall = ^stall;

    assign is_load   = mem_q.mem_en && (mem_q.wen == '0) && mem_q.sel_rf_res;
    assign reg_clear = flush || (state_q == DRAIN) || (stall[3] && !stall[4]);
    assign reg_load  = !reg_clear && !stall[3];
    assign reg_hold  = !reg_clear && stall[3];
    // load sitting in MEM whose data has not shown up yet this cycle
    assign ld_wait   = (state_q == IDLE) && is_load && !data_sram_rvalid;

    always_ff @(posedge clk) begin
        if (rst || reg_clear) begin
            mem_q <= '0;
        end else if (reg_load) begin
            mem_q <= '{pc: ex_pc, mem_en: ex_mem_en, wen: ex_mem_wen,
                       load_op: ex_load_op, sel_rf_res: ex_sel_rf_res,
                       rf_we: ex_rf_we, rf_waddr: ex_rf_waddr, result: ex_result};
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_cap    = 1'b0;
        buf_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_load && data_sram_rvalid) begin
                    // zero-wait data would be lost if the register stays put
                    if (reg_hold) begin
                        buf_cap = 1'b1;
                        state_d = HOLD;
                    end
                end else if (is_load) begin
                    state_d = flush ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (data_sram_rvalid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        buf_cap = 1'b1;
                        if (stall[4]) begin
                            state_d = HOLD;
                        end else begin
                            state_d    = IDLE;
                            buf_pend_d = 1'b1;
                        end
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (!reg_hold) state_d = IDLE;
            end
            DRAIN: begin
                // the flushed load's response is swallowed here
                if (data_sram_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_pend_q <= buf_pend_d;
            if (buf_cap) buf_q <= data_sram_rdata;
        end
    end

    assign use_buf = (state_q == HOLD) || buf_pend_q;
    assign ld_raw  = use_buf ? buf_q : data_sram_rdata;
    assign ld_byte = 8'(ld_raw >> {mem_q.result[1:0], 3'b000});
    assign ld_half = 16'(ld_raw >> {mem_q.result[1], 4'b0000});

    always_comb begin
        case (mem_q.load_op)
            OP_LB:   ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            OP_LH:   ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_ext = ld_raw;
        endcase
    end

    assign wdata        = mem_q.sel_rf_res ? ld_ext : mem_q.result;
    assign we_gate      = (state_q == WAIT) || (state_q == DRAIN) || ld_wait;
    assign stallreq_mem = we_gate;

    assign wb_pc        = mem_q.pc;
    assign wb_rf_we     = mem_q.rf_we && !we_gate;
    assign wb_rf_waddr  = mem_q.rf_waddr;
    assign wb_rf_wdata  = wdata;
    assign fwd_rf_we    = wb_rf_we;
    assign fwd_rf_waddr = wb_rf_waddr;
    assign fwd_rf_wdata = wb_rf_wdata;
endmodule

// File: tb/tb_mem_stage_ext.sv
// Bench for mem_stage_ext: directed cases plus randomized instruction stream
// scored against a transaction-level model of the stage and a latency-randomized SRAM.
module tb_mem_stage_ext;
    localparam int DATA_W = 32, PC_W = 32, RF_AW = 5, STALL_W = 6;
    localparam logic [5:0] ST_NONE = 6'b000000, ST_BUB = 6'b001111, ST_HOLD = 6'b011111;

    typedef struct packed {
        logic [31:0] pc;
        logic        mem_en;
        logic [3:0]  wen;
        logic [2:0]  op;
        logic        sel;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] res;
        logic [31:0] rdata;
        logic [1:0]  lat;
    } ins_t;

    logic clk = 1'b0, rst, flush;
    logic [STALL_W-1:0] stall, ext_stall;
    logic [PC_W-1:0] ex_pc, wb_pc;
    logic ex_mem_en, ex_sel_rf_res, ex_rf_we, data_sram_rvalid;
    logic [3:0] ex_mem_wen;
    logic [2:0] ex_load_op;
    logic [RF_AW-1:0] ex_rf_waddr, wb_rf_waddr, fwd_rf_waddr;
    logic [DATA_W-1:0] ex_result, data_sram_rdata, wb_rf_wdata, fwd_rf_wdata;
    logic stallreq_mem, wb_rf_we, fwd_rf_we;

    int n_chk = 0, n_fail = 0;
    logic [31:0] pc_ctr = 32'h1000;
    ins_t nop_i = '0;

    always #5 clk = ~clk;
    // stall controller: a MEM stall request freezes stages 0..4
    assign stall = stallreq_mem ? ST_HOLD : ext_stall;

    mem_stage_ext #(.DATA_W(DATA_W), .PC_W(PC_W), .RF_AW(RF_AW), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .ex_pc(ex_pc), .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen),
        .ex_load_op(ex_load_op), .ex_sel_rf_res(ex_sel_rf_res), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
        .data_sram_rdata(data_sram_rdata), .data_sram_rvalid(data_sram_rvalid),
        .stallreq_mem(stallreq_mem), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
        .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .fwd_rf_we(fwd_rf_we), .fwd_rf_waddr(fwd_rf_waddr), .fwd_rf_wdata(fwd_rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // load result from the ISA rules: pick byte/half by address, extend by op
    function automatic logic [31:0] exp_load(logic [2:0] op, logic [31:0] d, logic [1:0] off);
        int unsigned b, h;
        b = (d >> (8 * off)) % 256;
        h = (d >> (16 * off[1])) % 65536;
        case (op)
            3'd1:    return (b >= 128) ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    function automatic ins_t mk_ld(logic [2:0] op, logic [4:0] wa, logic [31:0] res);
        ins_t i = '0;
        i.pc = res + 32'h8000; i.mem_en = 1'b1; i.op = op; i.sel = 1'b1;
        i.we = 1'b1; i.wa = wa; i.res = res;
        return i;
    endfunction

    function automatic ins_t mk_alu(logic [4:0] wa, logic [31:0] res);
        ins_t i = '0;
        i.pc = res + 32'h9000; i.we = 1'b1; i.wa = wa; i.res = res;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i = '0;
        int k = $urandom_range(0, 2);
        pc_ctr = pc_ctr + 4;
        i.pc = pc_ctr; i.res = $urandom(); i.wa = 5'($urandom()); i.op = 3'($urandom());
        i.rdata = $urandom(); i.lat = 2'($urandom());
        if (k == 0) begin
            i.mem_en = 1'b1; i.sel = 1'b1; i.we = ($urandom_range(0, 7) != 0);
        end else if (k == 1) begin
            i.mem_en = 1'b1; i.wen = 4'($urandom_range(1, 15));
        end else begin
            i.we = 1'($urandom());
        end
        return i;
    endfunction

    task automatic drv(input ins_t i, input logic rv, input logic [31:0] rd,
                       input logic [5:0] es, input logic fl);
        ex_pc = i.pc; ex_mem_en = i.mem_en; ex_mem_wen = i.wen; ex_load_op = i.op;
        ex_sel_rf_res = i.sel; ex_rf_we = i.we; ex_rf_waddr = i.wa; ex_result = i.res;
        data_sram_rvalid = rv; data_sram_rdata = rd; ext_stall = es; flush = fl;
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
        chk({tag, "_we"}, 32'(wb_rf_we), 32'(we));
        chk({tag, "_fwd_we"}, 32'(fwd_rf_we), 32'(we));
        if (we) begin
            chk({tag, "_waddr"}, 32'(wb_rf_waddr), 32'(wa));
            chk({tag, "_wdata"}, wb_rf_wdata, wd);
            chk({tag, "_fwd_waddr"}, 32'(fwd_rf_waddr), 32'(wa));
            chk({tag, "_fwd_wdata"}, fwd_rf_wdata, wd);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // randomized run: model tracks which instruction sits in MEM and the one
    // outstanding SRAM response; a WB write is taken on every cycle WB advances
    task automatic run_random(input int ncyc);
        ins_t ex_i, mem_i;
        bit mem_v = 0, rp = 0, rv, fl, exp_we;
        int r_age = 0, r_lat = 0;
        logic [31:0] r_data = '0, rd, exp_wd;
        logic [5:0] es, st;
        int pick;
        ex_i = rand_ins(); mem_i = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            pick = $urandom_range(0, 9);
            es = (pick < 6) ? ST_NONE : (pick < 8) ? ST_BUB : ST_HOLD;
            fl = ($urandom_range(0, 19) == 0);
            rv = rp && (r_age == r_lat);
            rd = rv ? r_data : $urandom();
            // stray response with nothing pending must be ignored
            if (!rp && !(mem_v && mem_i.mem_en && mem_i.wen == 0 && mem_i.sel)
                && $urandom_range(0, 7) == 0)
                rv = 1'b1;
            drv(ex_i, rv, rd, es, fl);
            st = stall;
            chk("rnd_stallreq", 32'(stallreq_mem), 32'(rp && !(r_age == 0 && rv)));
            if (!st[4]) begin
                exp_we = mem_v && mem_i.we;
                exp_wd = mem_i.sel ? exp_load(mem_i.op, mem_i.rdata, mem_i.res[1:0]) : mem_i.res;
                chk_wb("rnd", exp_we, mem_i.wa, exp_wd);
                if (exp_we) chk("rnd_pc", wb_pc, mem_i.pc);
            end
            @(posedge clk);
            if (rp) begin
                if (r_age == r_lat) rp = 0;
                else r_age++;
            end
            if (fl) begin
                mem_v = 0; ex_i = rand_ins();
            end else if (st[3] && !st[4]) begin
                mem_v = 0;
            end else if (!st[3]) begin
                mem_i = ex_i; mem_v = 1;
                if (ex_i.mem_en && ex_i.wen == 0 && ex_i.sel) begin
                    rp = 1; r_age = 0; r_lat = int'(ex_i.lat); r_data = ex_i.rdata;
                end
                ex_i = rand_ins();
            end
        end
    endtask

    logic [2:0]  t2_op  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [1:0]  t2_off [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] t2_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h00000001};

    initial begin
        int sr_cnt;
        do_reset();
        @(negedge clk);
        drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        chk("rst_stallreq", 32'(stallreq_mem), 32'h0);
        chk_wb("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_wdata", wb_rf_wdata, 32'h0);
        chk("rst_pc", wb_pc, 32'h0);

        // zero-wait LW
        @(negedge clk); drv(mk_ld(3'd0, 5'd8, 32'h100), 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b1, 32'hDEADBEEF, ST_NONE, 1'b0);
        chk("t1_stallreq", 32'(stallreq_mem), 32'h0);
        chk_wb("t1", 1'b1, 5'd8, 32'hDEADBEEF);
        chk("t1_pc", wb_pc, 32'h8100);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        chk("t1_stallreq_after", 32'(stallreq_mem), 32'h0);

        // byte/half extension
        for (int e = 0; e < 5; e++) begin
            @(negedge clk); drv(mk_ld(t2_op[e], 5'd5, 32'h200 | 32'(t2_off[e])), 1'b0, 32'h0, ST_NONE, 1'b0);
            @(negedge clk); drv(nop_i, 1'b1, 32'h80FF7F01, ST_NONE, 1'b0);
            chk_wb($sformatf("t2_ext%0d", e), 1'b1, 5'd5, t2_exp[e]);
        end

        // response on the third MEM cycle
        sr_cnt = 0;
        @(negedge clk); drv(mk_ld(3'd0, 5'd10, 32'h300), 1'b0, 32'h0, ST_NONE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drv(nop_i, k == 2, (k == 2) ? 32'h0BADCAFE : $urandom(), ST_NONE, 1'b0);
            sr_cnt += int'(stallreq_mem);
            chk($sformatf("t3_we_wait%0d", k), 32'(wb_rf_we), 32'h0);
        end
        @(negedge clk); drv(nop_i, 1'b0, $urandom(), ST_NONE, 1'b0);
        sr_cnt += int'(stallreq_mem);
        chk("t3_stall_cycles", 32'(sr_cnt), 32'd3);
        chk_wb("t3_data", 1'b1, 5'd10, 32'h0BADCAFE);

        // flush while waiting: stale response dropped, next load unaffected
        @(negedge clk); drv(mk_ld(3'd0, 5'd11, 32'h400), 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b1);
        chk("t4_we_flush", 32'(wb_rf_we), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drv(nop_i, k == 2, 32'h12345678, ST_NONE, 1'b0);
            chk($sformatf("t4_drain_sr%0d", k), 32'(stallreq_mem), 32'h1);
            chk($sformatf("t4_drain_we%0d", k), 32'(wb_rf_we), 32'h0);
        end
        @(negedge clk); drv(mk_ld(3'd0, 5'd12, 32'h404), 1'b0, 32'h0, ST_NONE, 1'b0);
        chk("t4_idle_sr", 32'(stallreq_mem), 32'h0);
        chk("t4_idle_we", 32'(wb_rf_we), 32'h0);
        @(negedge clk); drv(nop_i, 1'b1, 32'hCAFEF00D, ST_NONE, 1'b0);
        chk_wb("t4_next", 1'b1, 5'd12, 32'hCAFEF00D);

        // stall combinations
        @(negedge clk); drv(mk_alu(5'd4, 32'h77), 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_HOLD, 1'b0);
        chk_wb("t5_alu", 1'b1, 5'd4, 32'h77);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_BUB, 1'b0);
        chk_wb("t5_held", 1'b1, 5'd4, 32'h77);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        chk("t5_bubble_we", 32'(wb_rf_we), 32'h0);
        @(negedge clk); drv(mk_ld(3'd3, 5'd6, 32'h502), 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b1, 32'h9ABC1234, ST_HOLD, 1'b0);
        chk_wb("t5_rv_hold", 1'b1, 5'd6, 32'hFFFF9ABC);
        @(negedge clk); drv(nop_i, 1'b0, $urandom(), ST_HOLD, 1'b0);
        chk("t5_hold_sr", 32'(stallreq_mem), 32'h0);
        chk_wb("t5_retained", 1'b1, 5'd6, 32'hFFFF9ABC);
        @(negedge clk); drv(nop_i, 1'b0, $urandom(), ST_NONE, 1'b0);
        chk_wb("t5_release", 1'b1, 5'd6, 32'hFFFF9ABC);
        @(negedge clk); drv(nop_i, 1'b0, $urandom(), ST_NONE, 1'b0);
        chk("t5_after_we", 32'(wb_rf_we), 32'h0);

        // reset while waiting
        @(negedge clk); drv(mk_ld(3'd0, 5'd13, 32'h600), 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        chk("t6_wait_sr", 32'(stallreq_mem), 32'h1);
        @(negedge clk); rst = 1'b1; drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        @(negedge clk); rst = 1'b0; drv(mk_alu(5'd3, 32'h55), 1'b0, 32'h0, ST_NONE, 1'b0);
        chk("t6_sr", 32'(stallreq_mem), 32'h0);
        chk("t6_we", 32'(wb_rf_we), 32'h0);
        chk("t6_waddr", 32'(wb_rf_waddr), 32'h0);
        chk("t6_wdata", wb_rf_wdata, 32'h0);
        chk("t6_pc", wb_pc, 32'h0);
        @(negedge clk); drv(nop_i, 1'b0, 32'h0, ST_NONE, 1'b0);
        chk_wb("t6_alu", 1'b1, 5'd3, 32'h55);

        do_reset();
        run_random(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ext.md
Name: mem_stage_ext

Overview:
Parametrised MEM pipeline stage for the five-stage CPU. It latches EX results under stall/flush control and completes loads from a data SRAM with variable response latency. Loads are byte/half/word with sign or zero extension selected by load op. The stage drives the WB stage and the ID forwarding path, and raises a stall request while a load response is outstanding.

Parameters:
DATA_W, 32, data/result width; multiple of 16
PC_W, 32, PC width
RF_AW, 5, register-file address width
STALL_W, 6, stall bus width; bit 3 = MEM, bit 4 = WB; Stop=1

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  clears MEM register (exception/redirect)
stall  in  STALL_W  pipeline stall vector
ex_pc  in  PC_W  PC of instruction leaving EX
ex_mem_en  in  1  data memory access issued in EX
ex_mem_wen  in  DATA_W/8  byte write enables; all-zero = load
ex_load_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others = LW
ex_sel_rf_res  in  1  1 = writeback from memory, 0 = from ex_result
ex_rf_we  in  1  register write enable
ex_rf_waddr  in  RF_AW  destination register
ex_result  in  DATA_W  ALU result / effective address
data_sram_rdata  in  DATA_W  load data, valid with rvalid
data_sram_rvalid  in  1  exactly one pulse per issued load
stallreq_mem  out  1  request stall of stages 0..4 while load pending
wb_pc  out  PC_W  to WB
wb_rf_we  out  1  to WB
wb_rf_waddr  out  RF_AW  to WB
wb_rf_wdata  out  DATA_W  to WB
fwd_rf_we  out  1  to ID forwarding (same value as wb_rf_we)
fwd_rf_waddr  out  RF_AW  to ID forwarding
fwd_rf_wdata  out  DATA_W  to ID forwarding

Behaviour:
- MEM register priority, checked each edge: rst -> clear; flush -> clear; stall[3]=Stop and stall[4]=NoStop -> clear (bubble); stall[3]=NoStop -> load EX fields; otherwise hold.
- Cleared register means rf_we=0, mem_en=0, and all fields 0.
- is_load = mem_en and (wen == 0) and sel_rf_res.
- FSM states are IDLE, WAIT, HOLD and DRAIN. Reset state is IDLE.
  - IDLE: when is_load and rvalid, use rdata combinationally and stay in IDLE (zero-wait). When is_load and not rvalid, go to WAIT.
  - WAIT: stallreq_mem=1 and wb_rf_we=0. On rvalid, capture rdata into the buffer. If stall[4]=Stop, go to HOLD; otherwise go to IDLE with the buffered data presented for one cycle. On flush, go to DRAIN (on the same edge, rvalid together with flush goes to IDLE).
  - HOLD: present buffered data and keep stallreq_mem=0. Return to IDLE when the MEM register next loads or clears.
  - DRAIN: register cleared and stallreq_mem=1. Discard the next rvalid, then go to IDLE. This prevents a stale response from being matched to a later load.
- rvalid is ignored in IDLE when there is no load.
- rst in any state goes to IDLE and deasserts stallreq_mem the next cycle. After reset, any in-flight response is the memory's responsibility to squash.
- Load extension uses off = ex_result[1:0]:
  - LB/LBU select byte off.
  - LH/LHU select half off[1].
  - LW uses the whole word and ignores off.
  - LB/LH sign-extend to DATA_W; LBU/LHU zero-extend.
  - Misaligned halves (off[0]=1) are not detected; off[1] is used.
- wb_rf_wdata = sel_rf_res ? extended load data : ex_result.
- wb_rf_we = rf_we, gated to 0 in WAIT and DRAIN.
- Stores complete without waiting and never assert stallreq_mem.
- The fwd_* outputs equal the wb_* values every cycle.
- All outputs are 0 after reset. Output latency is combinational from the MEM register and buffer, with no additional pipeline stage.

Test Plan:
1. Zero-wait LW. ex_result=0x100, rvalid in the first MEM cycle, rdata=0xDEADBEEF, waddr=8 -> same cycle wb_rf_we=1, waddr=8, wdata=0xDEADBEEF; stallreq_mem never high.
2. Extension. rdata=0x80FF7F01:
   - LB off=3 -> 0xFFFFFF80
   - LBU off=3 -> 0x00000080
   - LH off=2 -> 0xFFFF80FF
   - LHU off=0 -> 0x00007F01
   - LB off=0 -> 0x00000001
3. 3-cycle load latency. rvalid arrives 3 cycles after MEM entry -> stallreq_mem=1 for exactly 3 cycles; wb_rf_we=0 during the wait; the cycle after rvalid, wdata equals the captured rdata.
4. Flush during WAIT. The next rvalid carries 0x12345678 -> discarded; stallreq_mem stays 1 until it arrives; no register write occurs. A following LW with rdata=0xCAFEF00D writes 0xCAFEF00D.
5. Stall combinations:
   - stall[3]=1, stall[4]=0 -> bubble: wb_rf_we=0 next cycle.
   - stall[3]=1, stall[4]=1 -> register holds and outputs are unchanged.
   - rvalid while stall[4]=1 -> HOLD; data is retained until release.
6. Reset in WAIT -> next cycle stallreq_mem=0, all outputs 0, state IDLE. A non-load ALU op with result 0x55 and waddr=3 then passes through: wb_rf_wdata=0x55.
